pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RISC-V pipeline.
- Drives write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Sources of control: post-reset boot hold, data-memory wait handshake, taken branch/jump resolved in EX, and load-use hazards between ID and EX.
- Contains a small FSM plus boot and wait-timeout counters.

Parameters:
- BOOT_CYCLES, 4: cycles the pipeline is held flushed after reset release; legal range 1..2^CNT_W-1.
- WAIT_TIMEOUT, 255: maximum consecutive memory-wait cycles before a forced release; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the boot and wait counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- r  in  1  asynchronous, active-low reset.
- MemRead_ex  in  1  instruction in EX is a load.
- rdAddr_ex  in  5  destination register of the EX instruction.
- rs1Addr_id, rs2Addr_id  in  5 each  source registers of the ID instruction.
- rs1Used_id, rs2Used_id  in  1 each  ID instruction actually reads rs1 / rs2.
- BranchTaken_ex  in  1  branch taken or jump in EX; PC redirect this cycle.
- MemReq_mem  in  1  MEM stage is issuing a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC register load enable.
- IFID_Write  out  1  IF/ID register load enable.
- IFID_Flush  out  1  IF/ID register loads a bubble.
- IDEX_Write  out  1  ID/EX register load enable.
- IDEX_Flush  out  1  ID/EX register loads a bubble (all controls 0).
- EXMEM_Write  out  1  EX/MEM register load enable.
- MEMWB_Flush  out  1  MEM/WB register loads a bubble.
- boot_busy  out  1  high while in state BOOT.
- mem_timeout  out  1  sticky error flag: a memory wait exceeded WAIT_TIMEOUT.

Behaviour:
- States: BOOT, RUN, MEM_WAIT. Outputs are combinational from state and inputs; state and counters are registered.
- Reset (r=0, asynchronous):
  - State goes to BOOT; both counters clear to 0; mem_timeout=0.
  - Outputs: PCWrite=0, IFID_Write=0, IDEX_Write=0, EXMEM_Write=0, IFID_Flush=1, IDEX_Flush=1, MEMWB_Flush=1, boot_busy=1.
  - Reset asserted mid-operation (including during MEM_WAIT) aborts immediately to these values.
- BOOT:
  - Outputs as at reset; boot_cnt increments each clock.
  - When boot_cnt==BOOT_CYCLES-1, go to RUN. The first RUN cycle is exactly BOOT_CYCLES clocks after r rises.
- Freeze output set: PCWrite=0, IFID_Write=0, IDEX_Write=0, EXMEM_Write=0, MEMWB_Flush=1, IFID_Flush=0, IDEX_Flush=0.
- RUN priority, highest first:
  1. Memory wait (MemReq_mem=1 and mem_ready=0): freeze output set in the same cycle; next state MEM_WAIT; wait_cnt=1.
  2. BranchTaken_ex=1: PCWrite=1, IFID_Write=1, IDEX_Write=1, EXMEM_Write=1, IFID_Flush=1, IDEX_Flush=1. Branch overrides load-use because the hazarding instruction is on the wrong path.
  3. Load-use (MemRead_ex=1, rdAddr_ex!=0, and either rs1Used_id with rs1Addr_id==rdAddr_ex or rs2Used_id with rs2Addr_id==rdAddr_ex): PCWrite=0, IFID_Write=0, IDEX_Flush=1, IDEX_Write=1, EXMEM_Write=1. Exactly one bubble; on the next cycle the hazard is gone.
  4. Otherwise all Write=1 and all Flush=0.
- MEM_WAIT:
  - While mem_ready=0: freeze output set, wait_cnt increments.
  - If wait_cnt==WAIT_TIMEOUT with mem_ready=0: set mem_timeout (cleared only by reset) and release to RUN; this cycle is still frozen.
  - When mem_ready=1: evaluate RUN rules 2-4 in the same cycle, next state RUN.
  - BranchTaken_ex and load-use are not acted on while frozen. They are evaluated on the release cycle, because the EX contents are held.
- Load-use from x0 (rdAddr_ex=0) never stalls.
- MEMWB_Flush=0 in RUN.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - Adds 32-bit outputs stall_cycles, flush_events, wait_cycles, all reset to 0 and wrapping at 2^32.
  - stall_cycles increments on each load-use bubble.
  - flush_events increments on each taken-branch flush.
  - wait_cycles increments on each frozen cycle in RUN or MEM_WAIT; BOOT is not counted.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Boot: r low 3 cycles, then high with BOOT_CYCLES=4 -> boot_busy=1 and all Write=0 for 4 clocks; cycle 5 PCWrite=1 and boot_busy=0.
- Load-use: MemRead_ex=1, rdAddr_ex=5, rs2Addr_id=5, rs2Used_id=1 -> one cycle PCWrite=0, IFID_Write=0, IDEX_Flush=1. With rdAddr_ex=0 -> no stall.
- Branch plus load-use in the same cycle -> IFID_Flush=1, IDEX_Flush=1, PCWrite=1, no stall.
- Memory wait: MemReq_mem=1, mem_ready=0 for 3 cycles then 1 -> 3 frozen cycles with MEMWB_Flush=1; release cycle all Write=1; BranchTaken_ex held high during the wait flushes only on the release cycle.
- Timeout: WAIT_TIMEOUT=4, mem_ready stuck 0 -> mem_timeout rises after the 4th wait cycle and the pipeline resumes; flag stays 1 until r=0.
- Async reset asserted mid-MEM_WAIT between clock edges -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller signal bundle
//
// Purpose: groups the pipeline-side hazard inputs and the stall/flush
//   controls of pipeline_hazard_ctrl into one interface.
// Modports:
//   master - pipeline datapath: drives hazard/memory inputs, receives controls
//   slave  - pipeline_hazard_ctrl: receives inputs, drives controls
// Signals:
//   MemRead_ex, rdAddr_ex[4:0]          EX instruction is a load / its rd
//   rs1Addr_id, rs2Addr_id [4:0]        ID source registers
//   rs1Used_id, rs2Used_id              ID instruction really reads rs1/rs2
//   BranchTaken_ex                      redirect resolved in EX
//   MemReq_mem, mem_ready               data-memory request / completion
//   PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
//   EXMEM_Write, MEMWB_Flush            pipeline register controls
//   boot_busy, mem_timeout              status
//   stall_cycles, flush_events, wait_cycles [31:0]
//                                       present only with PIPE_PERF_CNT_EN
interface pipeline_hazard_ctrl_if;
  logic       MemRead_ex;
  logic [4:0] rdAddr_ex;
  logic [4:0] rs1Addr_id;
  logic [4:0] rs2Addr_id;
  logic       rs1Used_id;
  logic       rs2Used_id;
  logic       BranchTaken_ex;
  logic       MemReq_mem;
  logic       mem_ready;

  logic       PCWrite;
  logic       IFID_Write;
  logic       IFID_Flush;
  logic       IDEX_Write;
  logic       IDEX_Flush;
  logic       EXMEM_Write;
  logic       MEMWB_Flush;
  logic       boot_busy;
  logic       mem_timeout;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
  logic [31:0] wait_cycles;

  modport master (
    output MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id,
           rs2Used_id, BranchTaken_ex, MemReq_mem, mem_ready,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
           EXMEM_Write, MEMWB_Flush, boot_busy, mem_timeout,
           stall_cycles, flush_events, wait_cycles
  );

  modport slave (
    input  MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id,
           rs2Used_id, BranchTaken_ex, MemReq_mem, mem_ready,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
           EXMEM_Write, MEMWB_Flush, boot_busy, mem_timeout,
           stall_cycles, flush_events, wait_cycles
  );
`else
  modport master (
    output MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id,
           rs2Used_id, BranchTaken_ex, MemReq_mem, mem_ready,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
           EXMEM_Write, MEMWB_Flush, boot_busy, mem_timeout
  );

  modport slave (
    input  MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id,
           rs2Used_id, BranchTaken_ex, MemReq_mem, mem_ready,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
           EXMEM_Write, MEMWB_Flush, boot_busy, mem_timeout
  );
`endif
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline
//
// Purpose: drives write-enable and flush controls for PC, IF/ID, ID/EX,
//   EX/MEM and MEM/WB from a boot hold, the data-memory wait handshake,
//   taken branches resolved in EX and ID/EX load-use hazards.
// Ports:
//   clk  - clock, all state updates on posedge
//   r    - asynchronous active-low reset
//   hz   - pipeline_hazard_ctrl_if.slave, hazard inputs and control outputs
// Parameters:
//   BOOT_CYCLES  - cycles held flushed after reset release (1..2^CNT_W-1)
//   WAIT_TIMEOUT - memory-wait cycles before a forced release (1..2^CNT_W-1)
//   CNT_W        - boot / wait counter width
// Optional feature macro: PIPE_PERF_CNT_EN adds the 32-bit stall_cycles,
//   flush_events and wait_cycles counters on the interface.
module pipeline_hazard_ctrl #(
  parameter int BOOT_CYCLES  = 4,
  parameter int WAIT_TIMEOUT = 255,
  parameter int CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   r,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam logic [1:0] ST_BOOT     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_TIMEOUT);

  logic [1:0]       state;
  logic [CNT_W-1:0] boot_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_timeout_q;

  logic in_run;
  logic in_wait;
  logic in_boot;
  logic mem_stall;
  logic load_use;
  logic frozen;
  logic br_flush;
  logic lu_bubble;

  assign in_run  = (state == ST_RUN);
  assign in_wait = (state == ST_MEM_WAIT);
  // Any undecoded state behaves like BOOT so the pipeline stays flushed.
  assign in_boot = ~(in_run | in_wait);

  assign mem_stall = hz.MemReq_mem & ~hz.mem_ready;

  // A load writing x0 never creates a real dependency.
  assign load_use = hz.MemRead_ex && (hz.rdAddr_ex != 5'd0) &&
                    ((hz.rs1Used_id && (hz.rs1Addr_id == hz.rdAddr_ex)) ||
                     (hz.rs2Used_id && (hz.rs2Addr_id == hz.rdAddr_ex)));

  // In MEM_WAIT the request is already committed, so only mem_ready matters.
  assign frozen    = (in_run & mem_stall) | (in_wait & ~hz.mem_ready);
  // Branch wins over load-use: the hazarding instruction is on the wrong path.
  assign br_flush  = ~in_boot & ~frozen & hz.BranchTaken_ex;
  assign lu_bubble = ~in_boot & ~frozen & ~hz.BranchTaken_ex & load_use;

  assign hz.PCWrite     = ~in_boot & ~frozen & ~lu_bubble;
  assign hz.IFID_Write  = ~in_boot & ~frozen & ~lu_bubble;
  assign hz.IFID_Flush  = in_boot | br_flush;
  assign hz.IDEX_Write  = ~in_boot & ~frozen;
  assign hz.IDEX_Flush  = in_boot | br_flush | lu_bubble;
  assign hz.EXMEM_Write = ~in_boot & ~frozen;
  assign hz.MEMWB_Flush = in_boot | frozen;
  assign hz.boot_busy   = in_boot;
  assign hz.mem_timeout = mem_timeout_q;

  // wait_cnt is 1 on entry to MEM_WAIT and counts the MEM_WAIT cycles; the
  // cycle seeing wait_cnt==WAIT_TIMEOUT is the last frozen one.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state         <= ST_BOOT;
      boot_cnt      <= '0;
      wait_cnt      <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (boot_cnt == BOOT_LAST) begin
            state    <= ST_RUN;
            boot_cnt <= '0;
          end else begin
            boot_cnt <= boot_cnt + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= CNT_ONE;
          end
        end
        ST_MEM_WAIT: begin
          if (hz.mem_ready) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state         <= ST_RUN;
            wait_cnt      <= '0;
            mem_timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end
        default: begin
          state    <= ST_BOOT;
          boot_cnt <= '0;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;
  logic [31:0] wait_q;

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
      wait_q  <= 32'd0;
    end else begin
      if (lu_bubble) stall_q <= stall_q + 32'd1;
      if (br_flush)  flush_q <= flush_q + 32'd1;
      if (frozen)    wait_q  <= wait_q + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_events = flush_q;
  assign hz.wait_cycles  = wait_q;
`endif

endmodule
